as2650_extbus: RTL and testbench
================================

# as2650_extbus

Multiplexed external bus controller between the AS2650 core's memory port and the Caravel user I/O pads. Converts a single-outstanding CPU request (15-bit address, 8-bit data) into a pin-level cycle on a shared 8-bit address/data bus: two address-latch phases, a strobed data phase with programmable wait states, and a hold phase. Drives pad output-enable levels directly, so io_oeb semantics apply (1 = pad is an input).

## Interface
- WAIT_CYCLES, 1: extra data-phase cycles beyond the first (0–15).
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- cpu_req  in  1  transaction request; held high until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  15  byte address; stable while cpu_req is high.
- cpu_wdata  in  8  write data; stable while cpu_req is high.
- cpu_rdata  out  8  read data, registered.
- cpu_ready  out  1  one-cycle completion pulse.
- busy  out  1  high in any state other than IDLE.
- ad_out  out  8  multiplexed address/data pad outputs.
- ad_in  in  8  multiplexed address/data pad inputs.
- ad_oeb  out  8  pad output enables, active-low; all bits equal.
- ale_lo  out  1  low-address latch strobe, active-high.
- ale_hi  out  1  high-address latch strobe, active-high.
- rd_n  out  1  read strobe, active-low.
- wr_n  out  1  write strobe, active-low.
- ext_wait_n  in  1  external wait, active-low; present only with EXTBUS_WAIT_PIN_EN.

## Operation
- Reset values: state IDLE; ad_out=0x00, ad_oeb=0xFF, ale_lo=0, ale_hi=0, rd_n=1, wr_n=1, cpu_ready=0, cpu_rdata=0x00, busy=0, wait counter 0.
- All pad-side outputs and cpu_ready are registered. No combinational path from cpu_* inputs to pads.
- The controller latches cpu_we, cpu_addr and cpu_wdata when it leaves IDLE. Later changes to these inputs, or dropping cpu_req, do not affect the transaction in flight.
- IDLE: ad_oeb=0xFF, strobes inactive. cpu_req=1 -> ALO.
- ALO, 1 cycle: ad_out=addr[7:0], ad_oeb=0x00, ale_lo=1 -> AHI.
- AHI, 1 cycle: ad_out={1'b0,addr[14:8]}, ad_oeb=0x00, ale_hi=1 -> DATA. Counter loads WAIT_CYCLES.
- DATA, WAIT_CYCLES+1 cycles:
  - Read: rd_n=0, ad_oeb=0xFF.
  - Write: wr_n=0, ad_out=wdata, ad_oeb=0x00.
  - The counter decrements each cycle. When it is 0, the state goes to HOLD (subject to the wait pin; see Configuration).
  - On a read, ad_in is captured into cpu_rdata at the edge that leaves DATA.
- HOLD, 1 cycle: rd_n=wr_n=1 and cpu_ready=1.
  - Write: ad_out=wdata and ad_oeb=0x00 remain, for data hold.
  - Read: ad_oeb=0xFF.
  - Next state is IDLE.
- cpu_rdata holds its value until the next read completes. Writes do not change it.
- Turnaround: the IDLE cycle after HOLD is mandatory. A cpu_req still high in that cycle starts a new transaction, so the CPU must drop or re-present cpu_req on the cycle after cpu_ready.
- rd_n and wr_n are never low in the same cycle. ale_lo and ale_hi are never high together and are never high while a strobe is low.

## Timing
- Request sampled high in IDLE at edge N:
  - ale_lo is high in cycle N+1.
  - ale_hi is high in N+2.
  - The strobe is low in N+3 … N+3+WAIT_CYCLES.
  - cpu_ready is high in N+4+WAIT_CYCLES.
- Latency from request to ready is WAIT_CYCLES+4 cycles. Throughput is one transaction per WAIT_CYCLES+5 cycles.
- A reset asserted mid-transaction returns every output to its reset value at the next edge. No cpu_ready is issued for the aborted cycle.

## Configuration
- EXTBUS_WAIT_PIN_EN defined:
  - Adds port ext_wait_n and a 2-flop synchronizer, reset to 1.
  - In DATA with counter=0, the state stays in DATA (strobe low, read capture deferred) while the synchronized wait_n is 0. It exits at the first edge where it is 1.
  - Latency is therefore extended by 2-cycle synchronizer delay plus wait duration.
- Undefined: port absent; DATA length is exactly WAIT_CYCLES+1.

## Test plan
- Reset: hold wb_rst_i for 2 cycles during a write DATA phase -> next cycle ad_oeb=0xFF, wr_n=1, cpu_ready=0, busy=0. No ready pulse afterwards.
- Read, WAIT_CYCLES=1, addr=0x5A3C, ad_in=0xC3 during DATA:
  - ale_lo cycle shows ad_out=0x3C; ale_hi cycle shows 0x5A.
  - rd_n is low for 2 cycles.
  - cpu_ready pulses 5 cycles after request and cpu_rdata=0xC3.
- Write, WAIT_CYCLES=0, addr=0x7FFF, data=0xA5:
  - Address phases show 0xFF then 0x7F.
  - wr_n is low for 1 cycle with ad_out=0xA5, ad_oeb=0x00.
  - Data is still driven in HOLD; ready arrives at +4.
- Back-to-back: keep cpu_req high across ready with a new addr=0x0001 -> exactly one IDLE cycle, then ale_lo with ad_out=0x01. A write between two reads leaves cpu_rdata unchanged.
- Mid-transaction change: drop cpu_req and change cpu_addr during AHI -> the cycle completes with the original address and cpu_ready pulses once.
- EXTBUS_WAIT_PIN_EN, WAIT_CYCLES=0: hold ext_wait_n=0 from the ALO cycle for 4 cycles on a read -> rd_n stays low until 2 cycles after the wait_n rise, and the ad_in value at that final edge is captured.

Source files
------------

// File: rtl/as2650_extbus_if.sv
// Bus bundle for as2650_extbus: CPU memory port plus multiplexed pad signals.
// ext_wait_n exists only when EXTBUS_WAIT_PIN_EN is defined.
interface as2650_extbus_if;
  localparam int unsigned AW = 15;
  localparam int unsigned DW = 8;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ready;
  logic          busy;
  logic [DW-1:0] ad_out;
  logic [DW-1:0] ad_in;
  logic [DW-1:0] ad_oeb;
  logic          ale_lo;
  logic          ale_hi;
  logic          rd_n;
  logic          wr_n;
`ifdef EXTBUS_WAIT_PIN_EN
  logic          ext_wait_n;
`endif

  // Requesting side: the CPU core and the board behind the pads.
  modport master (
`ifdef EXTBUS_WAIT_PIN_EN
    output ext_wait_n,
`endif
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, ad_in,
    input  cpu_rdata, cpu_ready, busy, ad_out, ad_oeb, ale_lo, ale_hi, rd_n, wr_n
  );

  // Controller side.
  modport slave (
`ifdef EXTBUS_WAIT_PIN_EN
    input  ext_wait_n,
`endif
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ad_in,
    output cpu_rdata, cpu_ready, busy, ad_out, ad_oeb, ale_lo, ale_hi, rd_n, wr_n
  );
endinterface

// File: rtl/as2650_extbus.sv
// AS2650 external bus controller: ALO / AHI address latch phases, strobed data
// phase with WAIT_CYCLES wait states, HOLD. Optional wait pin: EXTBUS_WAIT_PIN_EN.
module as2650_extbus #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic            wb_clk_i,
  input logic            wb_rst_i,
  as2650_extbus_if.slave bus
);
  localparam int unsigned AW  = 15;
  localparam int unsigned DW  = 8;
  localparam int unsigned CW  = 4;
  localparam int unsigned AHW = AW - DW;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ALO  = 3'd1;
  localparam logic [2:0] ST_AHI  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_HOLD = 3'd4;

  logic [2:0]     state_q,   state_d;
  logic [CW-1:0]  cnt_q,     cnt_d;
  logic           we_q,      we_d;
  logic [AHW-1:0] addr_hi_q, addr_hi_d;
  logic [DW-1:0]  wdata_q,   wdata_d;
  logic [DW-1:0]  rdata_q,   rdata_d;
  logic [DW-1:0]  ad_out_q,  ad_out_d;
  logic [DW-1:0]  ad_oeb_q,  ad_oeb_d;
  logic           ale_lo_q,  ale_lo_d;
  logic           ale_hi_q,  ale_hi_d;
  logic           rd_n_q,    rd_n_d;
  logic           wr_n_q,    wr_n_d;
  logic           ready_q,   ready_d;
  logic           busy_q,    busy_d;
  logic           wait_ok;

`ifdef EXTBUS_WAIT_PIN_EN
  logic wait_s1_q, wait_s1_d;
  logic wait_s2_q, wait_s2_d;

  always_comb begin
    wait_s1_d = bus.ext_wait_n;
    wait_s2_d = wait_s1_q;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wait_s1_q <= 1'b1;
      wait_s2_q <= 1'b1;
    end else begin
      wait_s1_q <= wait_s1_d;
      wait_s2_q <= wait_s2_d;
    end
  end

  assign wait_ok = wait_s2_q;
`else
  assign wait_ok = 1'b1;
`endif

  // Next state and next pad levels; every output is a flop loaded from here.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_hi_d = addr_hi_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ad_out_d  = ad_out_q;
    ad_oeb_d  = {DW{1'b1}};
    ale_lo_d  = 1'b0;
    ale_hi_d  = 1'b0;
    rd_n_d    = 1'b1;
    wr_n_d    = 1'b1;
    ready_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cpu_req) begin
          state_d   = ST_ALO;
          we_d      = bus.cpu_we;
          addr_hi_d = bus.cpu_addr[AW-1:DW];
          wdata_d   = bus.cpu_wdata;
          ad_out_d  = bus.cpu_addr[DW-1:0];
          ad_oeb_d  = {DW{1'b0}};
          ale_lo_d  = 1'b1;
        end
      end

      ST_ALO: begin
        state_d  = ST_AHI;
        ad_out_d = {1'b0, addr_hi_q};
        ad_oeb_d = {DW{1'b0}};
        ale_hi_d = 1'b1;
      end

      ST_AHI: begin
        state_d = ST_DATA;
        cnt_d   = CW'(WAIT_CYCLES);
        if (we_q) begin
          wr_n_d   = 1'b0;
          ad_out_d = wdata_q;
          ad_oeb_d = {DW{1'b0}};
        end else begin
          rd_n_d = 1'b0;
        end
      end

      ST_DATA: begin
        if (cnt_q == '0 && wait_ok) begin
          state_d = ST_HOLD;
          ready_d = 1'b1;
          // Write data stays on the pads through HOLD for hold time.
          if (we_q) begin
            ad_out_d = wdata_q;
            ad_oeb_d = {DW{1'b0}};
          end else begin
            rdata_d = bus.ad_in;
          end
        end else begin
          if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
          if (we_q) begin
            wr_n_d   = 1'b0;
            ad_out_d = wdata_q;
            ad_oeb_d = {DW{1'b0}};
          end else begin
            rd_n_d = 1'b0;
          end
        end
      end

      ST_HOLD: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_hi_q <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ad_out_q  <= '0;
      ad_oeb_q  <= {DW{1'b1}};
      ale_lo_q  <= 1'b0;
      ale_hi_q  <= 1'b0;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_hi_q <= addr_hi_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ad_out_q  <= ad_out_d;
      ad_oeb_q  <= ad_oeb_d;
      ale_lo_q  <= ale_lo_d;
      ale_hi_q  <= ale_hi_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.ad_out    = ad_out_q;
  assign bus.ad_oeb    = ad_oeb_q;
  assign bus.ale_lo    = ale_lo_q;
  assign bus.ale_hi    = ale_hi_q;
  assign bus.rd_n      = rd_n_q;
  assign bus.wr_n      = wr_n_q;
endmodule

// File: tb/tb_as2650_extbus.sv
// Scoreboard bench for as2650_extbus: u0 runs WAIT_CYCLES=0, u1 runs WAIT_CYCLES=1.
// Wait-pin scenario is exercised when EXTBUS_WAIT_PIN_EN is defined.
module tb_as2650_extbus;
  typedef struct packed {
    logic [7:0] ad_out;
    logic [7:0] ad_oeb;
    logic       ale_lo;
    logic       ale_hi;
    logic       rd_n;
    logic       wr_n;
    logic       ready;
    logic       busy;
  } pads_t;

  typedef struct {
    logic [7:0] rdata;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic        req_r   [2];
  logic        we_r    [2];
  logic [14:0] addr_r  [2];
  logic [7:0]  wdata_r [2];
  logic [7:0]  ad_in_r [2];
  logic [7:0]  last_rd [2];
`ifdef EXTBUS_WAIT_PIN_EN
  logic        wait_n_r[2];
`endif

  exp_t  sbq0[$];
  exp_t  sbq1[$];
  pads_t obs0, obs1;

  as2650_extbus_if bus0();
  as2650_extbus_if bus1();

  assign bus0.cpu_req   = req_r[0];
  assign bus0.cpu_we    = we_r[0];
  assign bus0.cpu_addr  = addr_r[0];
  assign bus0.cpu_wdata = wdata_r[0];
  assign bus0.ad_in     = ad_in_r[0];
  assign bus1.cpu_req   = req_r[1];
  assign bus1.cpu_we    = we_r[1];
  assign bus1.cpu_addr  = addr_r[1];
  assign bus1.cpu_wdata = wdata_r[1];
  assign bus1.ad_in     = ad_in_r[1];
`ifdef EXTBUS_WAIT_PIN_EN
  assign bus0.ext_wait_n = wait_n_r[0];
  assign bus1.ext_wait_n = wait_n_r[1];
`endif

  assign obs0 = {bus0.ad_out, bus0.ad_oeb, bus0.ale_lo, bus0.ale_hi,
                 bus0.rd_n, bus0.wr_n, bus0.cpu_ready, bus0.busy};
  assign obs1 = {bus1.ad_out, bus1.ad_oeb, bus1.ale_lo, bus1.ale_hi,
                 bus1.rd_n, bus1.wr_n, bus1.cpu_ready, bus1.busy};

  as2650_extbus #(.WAIT_CYCLES(0)) u0 (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus0));
  as2650_extbus #(.WAIT_CYCLES(1)) u1 (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Expected pad levels k cycles after the request edge; dlen = data-phase length.
  task automatic check_pads(input int i, input int k, input int dlen, input logic we,
                            input logic [14:0] addr, input logic [7:0] wd);
    pads_t      o;
    logic [7:0] e_out = 8'h00;
    logic [7:0] e_oeb = 8'hFF;
    logic       e_lo = 1'b0, e_hi = 1'b0, e_rd = 1'b1, e_wr = 1'b1, e_rdy = 1'b0;
    logic       e_busy;
    bit         cmp_out = 1'b0;
    string      p;
    o = (i == 0) ? obs0 : obs1;
    p = $sformatf("u%0d k%0d ", i, k);
    if (k == 1) begin
      e_out = addr[7:0]; e_oeb = 8'h00; e_lo = 1'b1; cmp_out = 1'b1;
    end else if (k == 2) begin
      e_out = {1'b0, addr[14:8]}; e_oeb = 8'h00; e_hi = 1'b1; cmp_out = 1'b1;
    end else if (k >= 3 && k < 3 + dlen) begin
      if (we) begin e_wr = 1'b0; e_out = wd; e_oeb = 8'h00; cmp_out = 1'b1; end
      else e_rd = 1'b0;
    end else if (k == 3 + dlen) begin
      e_rdy = 1'b1;
      if (we) begin e_out = wd; e_oeb = 8'h00; cmp_out = 1'b1; end
    end
    e_busy = (k >= 1 && k <= 3 + dlen);
    check({p, "ad_oeb"}, 32'(o.ad_oeb), 32'(e_oeb));
    check({p, "ale_lo"}, 32'(o.ale_lo), 32'(e_lo));
    check({p, "ale_hi"}, 32'(o.ale_hi), 32'(e_hi));
    check({p, "rd_n"},   32'(o.rd_n),   32'(e_rd));
    check({p, "wr_n"},   32'(o.wr_n),   32'(e_wr));
    check({p, "ready"},  32'(o.ready),  32'(e_rdy));
    check({p, "busy"},   32'(o.busy),   32'(e_busy));
    if (cmp_out) check({p, "ad_out"}, 32'(o.ad_out), 32'(e_out));
  endtask

  task automatic check_reset(input int i);
    pads_t o;
    string p;
    o = (i == 0) ? obs0 : obs1;
    p = $sformatf("u%0d rst ", i);
    check({p, "ad_out"}, 32'(o.ad_out), 32'h00);
    check({p, "ad_oeb"}, 32'(o.ad_oeb), 32'hFF);
    check({p, "ale"},    32'({o.ale_lo, o.ale_hi}), 32'h0);
    check({p, "strobes"}, 32'({o.rd_n, o.wr_n}), 32'h3);
    check({p, "ready"},  32'(o.ready), 32'h0);
    check({p, "busy"},   32'(o.busy),  32'h0);
    check({p, "rdata"},  32'((i == 0) ? bus0.cpu_rdata : bus1.cpu_rdata), 32'h00);
  endtask

  task automatic idle_check(input int i);
    @(negedge clk);
    check_pads(i, 0, 1, 1'b0, 15'h0, 8'h00);
  endtask

  task automatic drive(input int i, input logic req, input logic we, input logic [14:0] addr,
                       input logic [7:0] wd, input logic [7:0] din);
    req_r[i] = req; we_r[i] = we; addr_r[i] = addr; wdata_r[i] = wd; ad_in_r[i] = din;
  endtask

  // Called at a negedge; returns at the negedge of the HOLD cycle.
  task automatic do_txn(input int i, input logic we, input logic [14:0] addr, input logic [7:0] wd,
                        input logic [7:0] din, input bit keep, input bit mid, input bit wtest);
    int   dlen;
    int   c;
    exp_t e;
    dlen = wtest ? 5 : ((i == 0) ? 1 : 2);
    drive(i, 1'b1, we, addr, wd, wtest ? 8'h11 : din);
    c = cyc;
    e.rdata = we ? last_rd[i] : din;
    e.cyc   = c + 3 + dlen;
    if (!we) last_rd[i] = din;
    if (i == 0) sbq0.push_back(e); else sbq1.push_back(e);
    for (int k = 1; k <= 3 + dlen; k++) begin
      @(negedge clk);
      check_pads(i, k, dlen, we, addr, wd);
      if (mid && k == 2) begin
        req_r[i] = 1'b0; addr_r[i] = ~addr; wdata_r[i] = ~wd; we_r[i] = ~we;
      end
`ifdef EXTBUS_WAIT_PIN_EN
      if (wtest && k == 1) wait_n_r[i] = 1'b0;
      if (wtest && k == 5) wait_n_r[i] = 1'b1;
      if (wtest && k == 7) ad_in_r[i] = din;
`endif
      if (k == 3 + dlen && !keep) req_r[i] = 1'b0;
    end
  endtask

  // Scoreboard: each ready pulse consumes one expected completion.
  always @(negedge clk) begin : mon0
    exp_t e;
    if (bus0.cpu_ready) begin
      check("u0 ready outstanding", 32'(sbq0.size() > 0), 32'd1);
      if (sbq0.size() > 0) begin
        e = sbq0.pop_front();
        check("u0 ready cycle", 32'(cyc), 32'(e.cyc));
        check("u0 rdata", 32'(bus0.cpu_rdata), 32'(e.rdata));
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (bus1.cpu_ready) begin
      check("u1 ready outstanding", 32'(sbq1.size() > 0), 32'd1);
      if (sbq1.size() > 0) begin
        e = sbq1.pop_front();
        check("u1 ready cycle", 32'(cyc), 32'(e.cyc));
        check("u1 rdata", 32'(bus1.cpu_rdata), 32'(e.rdata));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      drive(i, 1'b0, 1'b0, 15'h0, 8'h00, 8'h00);
      last_rd[i] = 8'h00;
`ifdef EXTBUS_WAIT_PIN_EN
      wait_n_r[i] = 1'b1;
`endif
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst = 1'b0;
    idle_check(0);
    idle_check(1);

    // Read with one wait state.
    do_txn(1, 1'b0, 15'h5A3C, 8'h00, 8'hC3, 1'b0, 1'b0, 1'b0);
    idle_check(1);
    idle_check(1);

    // Write with no wait states, top of address space.
    do_txn(0, 1'b1, 15'h7FFF, 8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0);
    idle_check(0);
    idle_check(0);

    // Back-to-back read / write / read with cpu_req held across ready.
    do_txn(1, 1'b0, 15'h1234, 8'h00, 8'h3E, 1'b1, 1'b0, 1'b0);
    idle_check(1);
    do_txn(1, 1'b1, 15'h0001, 8'h77, 8'hE1, 1'b1, 1'b0, 1'b0);
    check("u1 rdata after write", 32'(bus1.cpu_rdata), 32'h3E);
    idle_check(1);
    do_txn(1, 1'b0, 15'h0002, 8'h00, 8'h9D, 1'b0, 1'b0, 1'b0);
    idle_check(1);
    idle_check(1);

    // Request dropped and inputs scrambled during AHI.
    do_txn(1, 1'b0, 15'h2468, 8'h00, 8'h4B, 1'b0, 1'b1, 1'b0);
    repeat (3) idle_check(1);

`ifdef EXTBUS_WAIT_PIN_EN
    // Wait pin held low for four cycles from ALO on a read.
    do_txn(0, 1'b0, 15'h0123, 8'h00, 8'h5E, 1'b0, 1'b0, 1'b1);
    repeat (2) idle_check(0);
`endif

    // Reset during the data phase of a write.
    drive(1, 1'b1, 1'b1, 15'h1111, 8'h22, 8'h00);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check_pads(1, k, 2, 1'b1, 15'h1111, 8'h22);
    end
    rst = 1'b1;
    req_r[1] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_reset(1);
    end
    rst = 1'b0;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    repeat (6) idle_check(1);

    check("u0 pending", 32'(sbq0.size()), 32'd0);
    check("u1 pending", 32'(sbq1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
